// File: rtl/vec_scalar_regfile_sb_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vec_scalar_regfile_sb_if : issue/read/writeback bus of the regfile |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface vec_scalar_regfile_sb_if #(
  parameter int LANES  = 16,
  parameter int DATA_W = 32,
  parameter int NREGS  = 16
);
  localparam int AW = $clog2(NREGS);

  logic [DATA_W-1:0]       pc_in;
  logic [AW-1:0]           ra1;
  logic [AW-1:0]           ra2;
  logic                    rsel_vec;
  logic [LANES*DATA_W-1:0] rd1;
  logic [LANES*DATA_W-1:0] rd2;
  logic                    rd1_busy;
  logic                    rd2_busy;
  logic                    we;
  logic                    wsel_vec;
  logic [AW-1:0]           waddr;
  logic [LANES-1:0]        wmask;
  logic                    wbcast;
  logic [LANES*DATA_W-1:0] wdata;
  logic                    iss_valid;
  logic [AW-1:0]           iss_dst;
  logic                    iss_vec;

  modport master (
    output pc_in, ra1, ra2, rsel_vec, we, wsel_vec, waddr, wmask, wbcast,
           wdata, iss_valid, iss_dst, iss_vec,
    input  rd1, rd2, rd1_busy, rd2_busy
  );

  modport slave (
    input  pc_in, ra1, ra2, rsel_vec, we, wsel_vec, waddr, wmask, wbcast,
           wdata, iss_valid, iss_dst, iss_vec,
    output rd1, rd2, rd1_busy, rd2_busy
  );
endinterface
`default_nettype wire

// File: rtl/vec_scalar_regfile_sb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vec_scalar_regfile_sb : vector/scalar regfile, bypass, busy sb    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module vec_scalar_regfile_sb #(
  parameter int LANES  = 16,
  parameter int DATA_W = 32,
  parameter int NREGS  = 16
) (
  input wire logic               clk,
  input wire logic               rst,
  vec_scalar_regfile_sb_if.slave bus
);
  localparam int            AW      = $clog2(NREGS);
  localparam logic [AW-1:0] PC_ADDR = AW'(NREGS-1);

  typedef logic [LANES-1:0][DATA_W-1:0] row_t;

  row_t              vreg_q [NREGS];
  logic [DATA_W-1:0] sreg_q [NREGS-1];
  logic [NREGS-1:0]  busy_s_q, busy_s_d;
  logic [NREGS-1:0]  busy_v_q, busy_v_d;

  row_t              wdata_w;
  row_t              vwr_row;
  logic              vwr;
  logic              swr;
  logic [1:0][AW-1:0] ra;
  row_t              rd [2];
  logic [1:0]        rd_busy;

  assign wdata_w = bus.wdata;
  assign vwr     = bus.we & bus.wsel_vec;
  assign swr     = bus.we & ~bus.wsel_vec & (bus.waddr != PC_ADDR);
  assign ra      = {bus.ra2, bus.ra1};

  // Post-write image of the target vector row; feeds both the array and the bypass.
  always_comb begin
    vwr_row = vreg_q[bus.waddr];
    for (int i = 0; i < LANES; i++) begin
      if (bus.wmask[i]) begin
        vwr_row[i] = bus.wbcast ? wdata_w[LANES-1] : wdata_w[i];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p]      = '0;
      rd_busy[p] = 1'b0;
      if (bus.rsel_vec) begin
        rd[p]      = (vwr && (bus.waddr == ra[p])) ? vwr_row : vreg_q[ra[p]];
        rd_busy[p] = busy_v_q[ra[p]];
      end else begin
        if (ra[p] == PC_ADDR) begin
          rd[p][LANES-1] = bus.pc_in;
        end else if (swr && (bus.waddr == ra[p])) begin
          rd[p][LANES-1] = wdata_w[LANES-1];
        end else begin
          rd[p][LANES-1] = sreg_q[ra[p]];
        end
        rd_busy[p] = busy_s_q[ra[p]];
      end
    end
  end

  assign bus.rd1      = rd[0];
  assign bus.rd2      = rd[1];
  assign bus.rd1_busy = rd_busy[0];
  assign bus.rd2_busy = rd_busy[1];

  // Clear on writeback first so a same-cycle issue to the same register wins.
  always_comb begin
    busy_s_d = busy_s_q;
    busy_v_d = busy_v_q;
    if (bus.we) begin
      if (bus.wsel_vec) busy_v_d[bus.waddr] = 1'b0;
      else              busy_s_d[bus.waddr] = 1'b0;
    end
    if (bus.iss_valid) begin
      if (bus.iss_vec)                   busy_v_d[bus.iss_dst] = 1'b1;
      else if (bus.iss_dst != PC_ADDR)   busy_s_d[bus.iss_dst] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++)     vreg_q[r] <= '0;
      for (int r = 0; r < NREGS - 1; r++) sreg_q[r] <= '0;
      busy_s_q <= '0;
      busy_v_q <= '0;
    end else begin
      if (vwr) vreg_q[bus.waddr] <= vwr_row;
      if (swr) sreg_q[bus.waddr] <= wdata_w[LANES-1];
      busy_s_q <= busy_s_d;
      busy_v_q <= busy_v_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_vec_scalar_regfile_sb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_vec_scalar_regfile_sb : scoreboard bench for the regfile       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_vec_scalar_regfile_sb;
  typedef logic [15:0][31:0] row_t;
  typedef struct {
    string name;
    row_t  rd1;
    row_t  rd2;
    logic  b1;
    logic  b2;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sbq[$];
  event probe_ev;

  vec_scalar_regfile_sb_if #(.LANES(16), .DATA_W(32), .NREGS(16)) bus ();

  vec_scalar_regfile_sb #(.LANES(16), .DATA_W(32), .NREGS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic row_t seq(input logic [31:0] base, input logic [15:0] m);
    row_t r;
    r = '0;
    for (int i = 0; i < 16; i++) if (m[i]) r[i] = base + 32'(i);
    return r;
  endfunction

  function automatic row_t fill(input logic [31:0] v, input logic [15:0] m);
    row_t r;
    r = '0;
    for (int i = 0; i < 16; i++) if (m[i]) r[i] = v;
    return r;
  endfunction

  function automatic row_t srow(input logic [31:0] v);
    row_t r;
    r = '0;
    r[15] = v;
    return r;
  endfunction

  task automatic chk_row(input string n, input row_t act, input row_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic chk_bit(input string n, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", n, act, exp);
    end
  endtask

  // Monitor: drains the expectation queue whenever outputs are sampled.
  initial begin
    exp_t e;
    row_t a1;
    row_t a2;
    forever begin
      @(negedge clk or probe_ev);
      while (sbq.size() > 0) begin
        e  = sbq.pop_front();
        a1 = bus.rd1;
        a2 = bus.rd2;
        chk_row({e.name, ".rd1"}, a1, e.rd1);
        chk_row({e.name, ".rd2"}, a2, e.rd2);
        chk_bit({e.name, ".rd1_busy"}, bus.rd1_busy, e.b1);
        chk_bit({e.name, ".rd2_busy"}, bus.rd2_busy, e.b2);
      end
    end
  end

  task automatic expect_rd(input string n, input row_t e1, input row_t e2,
                           input logic b1, input logic b2);
    exp_t x;
    x.name = n;
    x.rd1  = e1;
    x.rd2  = e2;
    x.b1   = b1;
    x.b2   = b2;
    sbq.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.we        = 1'b0;
    bus.iss_valid = 1'b0;
  endtask

  task automatic setrd(input logic vec, input logic [3:0] a1, input logic [3:0] a2);
    bus.rsel_vec = vec;
    bus.ra1      = a1;
    bus.ra2      = a2;
  endtask

  task automatic wr(input logic vec, input logic [3:0] a, input logic [15:0] m,
                    input logic bc, input row_t d);
    bus.we       = 1'b1;
    bus.wsel_vec = vec;
    bus.waddr    = a;
    bus.wmask    = m;
    bus.wbcast   = bc;
    bus.wdata    = d;
  endtask

  task automatic issue(input logic vec, input logic [3:0] dst);
    bus.iss_valid = 1'b1;
    bus.iss_vec   = vec;
    bus.iss_dst   = dst;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    row_t d;
    row_t v2m;
    row_t bc5;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.pc_in = 32'h100;
    bus.ra1 = '0; bus.ra2 = '0; bus.rsel_vec = 1'b0;
    bus.we = 1'b0; bus.wsel_vec = 1'b0; bus.waddr = '0; bus.wmask = '0;
    bus.wbcast = 1'b0; bus.wdata = '0;
    bus.iss_valid = 1'b0; bus.iss_dst = '0; bus.iss_vec = 1'b0;
    v2m = seq(32'h1, 16'h00FF) | seq(32'hA0, 16'h0F00);
    bc5 = fill(32'hDEADBEEF, 16'hF00F);
    @(posedge clk);
    #1;

    setrd(1, 3, 15); expect_rd("rst_vec", '0, '0, 0, 0); step();
    rst = 1'b0;
    setrd(0, 15, 3); expect_rd("pc_read", srow(32'h100), '0, 0, 0); step();

    wr(1, 2, 16'h00FF, 0, seq(32'h1, 16'hFFFF));
    setrd(1, 2, 5); expect_rd("byp_v2", seq(32'h1, 16'h00FF), '0, 0, 0); step();
    setrd(1, 2, 5); expect_rd("v2_after", seq(32'h1, 16'h00FF), '0, 0, 0); step();
    wr(1, 2, 16'h0F00, 0, seq(32'hA0, 16'hFFFF));
    setrd(1, 2, 2); expect_rd("byp_merge", v2m, v2m, 0, 0); step();

    d = seq(32'h10, 16'hFFFF); d[15] = 32'hDEADBEEF;
    wr(1, 5, 16'hF00F, 1, d);
    setrd(1, 5, 2); expect_rd("bcast_byp", bc5, v2m, 0, 0); step();
    setrd(1, 5, 3); expect_rd("bcast_v5", bc5, '0, 0, 0); step();

    d = seq(32'h7, 16'hFFFF); d[15] = 32'd44;
    wr(0, 4, 16'h0000, 1, d);
    setrd(0, 4, 15); expect_rd("s4_byp", srow(32'd44), srow(32'h100), 0, 0); step();
    d[15] = 32'h55;
    wr(0, 15, 16'hFFFF, 0, d);
    setrd(0, 15, 4); expect_rd("pc_wr_ignored", srow(32'h100), srow(32'd44), 0, 0); step();
    bus.pc_in = 32'h204;
    setrd(0, 15, 4); expect_rd("pc_follow", srow(32'h204), srow(32'd44), 0, 0); step();
    wr(1, 4, 16'hFFFF, 0, seq(32'h40, 16'hFFFF));
    setrd(0, 4, 15); expect_rd("xfile_nobyp", srow(32'd44), srow(32'h204), 0, 0); step();
    setrd(1, 4, 2); expect_rd("v4", seq(32'h40, 16'hFFFF), v2m, 0, 0); step();

    issue(1, 7);
    setrd(1, 7, 7); expect_rd("iss_same_cyc", '0, '0, 0, 0); step();
    issue(0, 15);
    setrd(1, 7, 2); expect_rd("v7_busy", '0, v2m, 1, 0); step();
    issue(0, 3);
    setrd(0, 7, 15); expect_rd("s7_s15_idle", '0, srow(32'h204), 0, 0); step();
    wr(1, 7, 16'h0000, 0, seq(32'h1, 16'hFFFF)); issue(1, 7);
    setrd(1, 7, 5); expect_rd("wb_iss_pre", '0, bc5, 1, 0); step();
    setrd(1, 7, 7); expect_rd("set_wins", '0, '0, 1, 1); step();
    d = '0; d[15] = 32'd33;
    wr(0, 3, 16'h0000, 0, d);
    setrd(0, 7, 3); expect_rd("s3_wb", '0, srow(32'd33), 0, 1); step();
    wr(1, 7, 16'h0001, 0, seq(32'h77, 16'hFFFF));
    setrd(1, 7, 7); expect_rd("wb_v7", seq(32'h77, 16'h0001), seq(32'h77, 16'h0001), 1, 1); step();
    setrd(1, 7, 2); expect_rd("v7_free", seq(32'h77, 16'h0001), v2m, 0, 0); step();
    setrd(0, 3, 7); expect_rd("s3_free", srow(32'd33), '0, 0, 0); step();

    issue(1, 7); step();
    setrd(1, 7, 2); expect_rd("pre_rst", seq(32'h77, 16'h0001), v2m, 1, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    expect_rd("async_rst", '0, '0, 0, 0);
    ->probe_ev;
    #1;
    step();
    rst = 1'b0;

    d = seq(32'h90, 16'hFFFF);
    wr(1, 7, 16'h8000, 0, d);
    setrd(1, 7, 7); expect_rd("late_wb_byp", seq(32'h90, 16'h8000), seq(32'h90, 16'h8000), 0, 0); step();
    setrd(1, 7, 2); expect_rd("late_wb", seq(32'h90, 16'h8000), '0, 0, 0); step();

    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/vec_scalar_regfile_sb.md
Name: vec_scalar_regfile_sb

Overview:
- Parametrised successor to the core's scalar/vector register file.
- Holds NREGS vector registers of LANES x DATA_W bits and NREGS-1 scalar registers. The top scalar address reads the PC input.
- New capabilities:
  - per-lane write mask
  - scalar-to-vector broadcast write
  - same-cycle write-to-read bypass
  - busy scoreboard, which gives the issue stage hazard flags for multi-cycle ops.
- Sits between decode/issue and the execute/writeback stages of the SIMD pipeline.

Parameters:
- LANES, 16, number of vector lanes; lane LANES-1 is the scalar lane.
- DATA_W, 32, bits per lane and per scalar register.
- NREGS, 16, number of register addresses, 2..32.
- AW, $clog2(NREGS), address width (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- pc_in  in  DATA_W  value returned for scalar address NREGS-1.
- ra1, ra2  in  AW  read addresses.
- rsel_vec  in  1  0 = scalar read, 1 = vector read (both ports).
- rd1, rd2  out  LANES*DATA_W  read data.
- rd1_busy, rd2_busy  out  1  scoreboard bit of the addressed register (scalar or vector file per rsel_vec).
- we  in  1  write enable.
- wsel_vec  in  1  0 = scalar write, 1 = vector write.
- waddr  in  AW  write address.
- wmask  in  LANES  per-lane write enable (vector writes only).
- wbcast  in  1  broadcast wdata lane LANES-1 to all masked lanes.
- wdata  in  LANES*DATA_W  write data.
- iss_valid  in  1  marks issue of an op whose destination is iss_dst/iss_vec.
- iss_dst  in  AW  issued destination.
- iss_vec  in  1  issued destination is a vector register.

Behaviour:
- Reset, asynchronous: all vector lanes, all scalar registers and both busy vectors go to 0. rd1_busy and rd2_busy read 0 during reset. rd1/rd2 show zeroed contents, or pc_in at the PC address.
- Vector write, we & wsel_vec, at posedge:
  - for each lane i with wmask[i]=1: vreg[waddr][i] <= wbcast ? wdata[LANES-1] : wdata[i].
  - lanes with wmask[i]=0 are unchanged.
  - wmask=0 writes nothing but still counts as a writeback for the scoreboard.
- Scalar write, we & ~wsel_vec: sreg[waddr] <= wdata[LANES-1]. wmask and wbcast are ignored. A write to address NREGS-1 is discarded, because that address is the PC.
- Scalar read, rsel_vec=0:
  - rdN lane LANES-1 = (raN==NREGS-1) ? pc_in : sreg[raN].
  - lanes 0..LANES-2 = 0.
- Vector read, rsel_vec=1: rdN = vreg[raN], all lanes.
- Reads are combinational, zero latency.
- Bypass: when we is set this cycle, the write target matches the read (same file, waddr==raN) and the address is not the PC, rdN returns the post-write value of each lane this cycle. That is, masked lanes show the new (or broadcast) data; unmasked lanes show the old data.
- Scoreboard: two NREGS-bit vectors, busy_s and busy_v. At posedge:
  - iss_valid sets busy_{iss_vec?v:s}[iss_dst].
  - we clears busy_{wsel_vec?v:s}[waddr].
  - issue and writeback to the same register in the same cycle: set wins, so the new op is outstanding.
  - issue to scalar NREGS-1 is ignored (busy_s[NREGS-1] is always 0).
  - writeback to a non-busy register is legal; the bit stays 0.
- rdN_busy = addressed busy bit, registered state only. No bypass of same-cycle issue/writeback.
- Write and read of the same register with rsel_vec != wsel_vec: no bypass, since the files are separate.
- Reset during an outstanding op: all busy bits clear; a late writeback after reset writes data normally.

Test Plan:
- Reset, then vector read of v3 -> all lanes 0; scalar read of address 15 with pc_in=0x100 -> lane 15 = 0x100, other lanes 0; busy=0.
- Vector write v2, wmask=0x00FF, wdata lane i = i+1 -> next cycle v2 lanes 0..7 = 1..8, lanes 8..15 = 0. In the write cycle, ra1=2 with rsel_vec=1 shows the same values through the bypass.
- Broadcast write v5, wmask=0xF00F, wbcast=1, wdata lane 15 = 0xDEADBEEF -> lanes 0-3 and 12-15 = 0xDEADBEEF, others 0.
- Scalar write s4=44, then scalar write to address 15 of 0x55 -> s4 reads 44; address 15 still reads pc_in.
- iss_valid v7 -> rd1_busy=1 with ra1=7, rsel_vec=1, from the next cycle. Writeback v7 alongside a new iss_valid v7 in the same cycle -> busy stays 1. A later writeback alone -> busy 0. busy_s[7] remains 0 throughout.
- Assert rst asynchronously mid-cycle with v7 busy and v2 nonzero -> busy and data clear immediately, without waiting for a clock edge.
